// File: rtl/ipsxe_floating_point_pkg.sv
// Shared definitions for the floating-point datapath.
//   RM_*   : IEEE-754 rounding-mode encodings carried on the 3-bit mode buses.
//   grd_w(): number of round bits below the stored mantissa in a significand
//            that carries the hidden bit in its MSB.
package ipsxe_floating_point_pkg;

  localparam logic [2:0] RM_RNE = 3'd0;  // nearest, ties to even
  localparam logic [2:0] RM_RTZ = 3'd1;  // toward zero
  localparam logic [2:0] RM_RUP = 3'd2;  // toward +inf
  localparam logic [2:0] RM_RDN = 3'd3;  // toward -inf
  localparam logic [2:0] RM_RMM = 3'd4;  // nearest, ties away from zero

  function automatic int grd_w(input int bin_w, input int man_w);
    return bin_w - 1 - man_w;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_round_dec_v1_0.sv
// Combinational rounding decision shared by the floating-point back-ends.
// Ports:
//   mode    in  3  rounding mode (RM_*; unused encodings behave as RNE)
//   sign    in  1  sign of the value being rounded
//   lsb     in  1  least significant kept mantissa bit
//   g       in  1  first discarded (guard) bit
//   s       in  1  OR of all remaining discarded bits
//   inc     out 1  add one ulp to the kept mantissa
//   inexact out 1  at least one discarded bit is set
module ipsxe_floating_point_round_dec_v1_0
  import ipsxe_floating_point_pkg::*;
(
  input  logic [2:0] mode,
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       s,
  output logic       inc,
  output logic       inexact
);

  always_comb begin
    inc = 1'b0;
    case (mode)
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (g | s) & ~sign;
      RM_RDN:  inc = (g | s) & sign;
      RM_RMM:  inc = g;
      default: inc = g & (s | lsb);  // RNE and reserved encodings
    endcase
  end

  assign inexact = g | s;

endmodule

// File: rtl/ipsxe_floating_point_rounder_pipe_v1_0.sv
// Two-stage elastic rounding stage: rounds a normalised significand to MAN_W
// mantissa bits, carries into the exponent and flags inexact/overflow.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_valid / o_ready      input handshake
//   i_bin, i_sign, i_exp   significand (hidden bit in MSB), sign, biased exponent
//   i_mode                 rounding mode (RM_*)
//   o_valid / i_ready      output handshake
//   o_man, o_exp, o_sign   rounded result
//   o_inexact, o_overflow  status flags
module ipsxe_floating_point_rounder_pipe_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int MAN_W = 23,
  parameter int EXP_W = 8,
  parameter int BIN_W = 28
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [BIN_W-1:0] i_bin,
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [2:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [MAN_W-1:0] o_man,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_sign,
  output logic             o_inexact,
  output logic             o_overflow
);

  localparam int GRD = grd_w(BIN_W, MAN_W);

  generate
    if (GRD < 2) begin : g_bad_grd
      $error("BIN_W must leave at least two round bits below the mantissa");
    end
  endgenerate

  // Hidden bit is implied by normalisation and never examined.
  logic unused_hidden;
  assign unused_hidden = i_bin[BIN_W-1];

  // ---------------- stage 1: split fields, decide increment ----------------
  logic [MAN_W-1:0] in_m;
  logic             in_g, in_s, in_special;
  logic             dec_inc, dec_inexact;

  assign in_m       = i_bin[BIN_W-2:GRD];
  assign in_g       = i_bin[GRD-1];
  assign in_s       = |i_bin[GRD-2:0];
  assign in_special = &i_exp;  // inf/NaN pass through untouched

  ipsxe_floating_point_round_dec_v1_0 u_dec (
    .mode    (i_mode),
    .sign    (i_sign),
    .lsb     (in_m[0]),
    .g       (in_g),
    .s       (in_s),
    .inc     (dec_inc),
    .inexact (dec_inexact)
  );

  logic             s1_valid, s2_valid;
  logic [MAN_W-1:0] s1_m;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_inc, s1_inexact, s1_sign, s1_special;

  logic s2_adv, s1_load;
  assign s2_adv  = ~s2_valid | i_ready;
  assign o_ready = ~s1_valid | s2_adv;
  assign s1_load = i_valid & o_ready;
  assign o_valid = s2_valid;

  // ---------------- stage 2: add, carry into exponent ----------------
  logic [MAN_W:0]   sum;
  logic [EXP_W-1:0] exp_adj;
  logic             ovf;
  logic [MAN_W-1:0] man_rnd;

  always_comb begin
    sum     = {1'b0, s1_m} + (MAN_W + 1)'(s1_inc);
    exp_adj = sum[MAN_W] ? s1_exp + EXP_W'(1) : s1_exp;
    ovf     = ~s1_special & (&exp_adj);
    // Carry-out leaves 1.000.. whose stored mantissa is zero; overflow is infinity.
    man_rnd = (sum[MAN_W] | ovf) ? '0 : sum[MAN_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid   <= 1'b0;
      s1_m       <= '0;
      s1_exp     <= '0;
      s1_inc     <= 1'b0;
      s1_inexact <= 1'b0;
      s1_sign    <= 1'b0;
      s1_special <= 1'b0;
      s2_valid   <= 1'b0;
      o_man      <= '0;
      o_exp      <= '0;
      o_sign     <= 1'b0;
      o_inexact  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      // When o_ready is high stage 1 is empty or moving on, so it takes i_valid.
      if (o_ready) s1_valid <= i_valid;
      if (s1_load) begin
        s1_m       <= in_m;
        s1_exp     <= i_exp;
        s1_inc     <= dec_inc & ~in_special;
        s1_inexact <= dec_inexact & ~in_special;
        s1_sign    <= i_sign;
        s1_special <= in_special;
      end
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv & s1_valid) begin
        o_man      <= man_rnd;
        o_exp      <= exp_adj;
        o_sign     <= s1_sign;
        o_inexact  <= s1_inexact;
        o_overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_rounder_pipe_v1_0.sv
module tb_ipsxe_floating_point_rounder_pipe_v1_0;

  localparam int MW = 4;
  localparam int EW = 4;
  localparam int BW = 8;

  typedef struct packed {
    logic [MW-1:0] man;
    logic [EW-1:0] exp;
    logic          sign;
    logic          inexact;
    logic          overflow;
  } res_t;

  typedef struct packed {
    logic [BW-1:0] bin;
    logic          sign;
    logic [EW-1:0] exp;
    logic [2:0]    mode;
    res_t          want;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [BW-1:0] i_bin = '0;
  logic          i_sign = 1'b0;
  logic [EW-1:0] i_exp = '0;
  logic [2:0]    i_mode = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [MW-1:0] o_man;
  logic [EW-1:0] o_exp;
  logic          o_sign, o_inexact, o_overflow;

  int n_vec = 0;
  int n_err = 0;

  ipsxe_floating_point_rounder_pipe_v1_0 #(
    .MAN_W (MW),
    .EXP_W (EW),
    .BIN_W (BW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_bin      (i_bin),
    .i_sign     (i_sign),
    .i_exp      (i_exp),
    .i_mode     (i_mode),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_man      (o_man),
    .o_exp      (o_exp),
    .o_sign     (o_sign),
    .o_inexact  (o_inexact),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic res_t got_res();
    return {o_man, o_exp, o_sign, o_inexact, o_overflow};
  endfunction

  // Rounding from the arithmetic value: kept part, discarded remainder vs. one half ulp.
  function automatic res_t model(logic [BW-1:0] bin, logic sign, logic [EW-1:0] exp,
                                 logic [2:0] mode);
    res_t r;
    int m, rem, up, val, e;
    m   = int'(bin[BW-2:3]);
    rem = int'(bin[2:0]);
    r.sign = sign;
    if (exp == 4'hF) begin
      r.man = bin[BW-2:3]; r.exp = exp; r.inexact = 1'b0; r.overflow = 1'b0;
      return r;
    end
    r.inexact = (rem != 0);
    case (mode)
      3'd1:    up = 0;
      3'd2:    up = (rem != 0 && !sign) ? 1 : 0;
      3'd3:    up = (rem != 0 && sign) ? 1 : 0;
      3'd4:    up = (rem >= 4) ? 1 : 0;
      default: up = (rem > 4 || (rem == 4 && (m % 2) == 1)) ? 1 : 0;
    endcase
    val = m + up;
    e   = int'(exp);
    if (val == 16) begin val = 0; e = e + 1; end
    r.overflow = (e == 15);
    if (r.overflow) val = 0;
    r.man = 4'(val);
    r.exp = 4'(e);
    return r;
  endfunction

  function automatic vec_t mk(logic [BW-1:0] bin, logic sign, logic [EW-1:0] exp,
                              logic [2:0] mode, res_t want);
    vec_t v;
    v.bin = bin; v.sign = sign; v.exp = exp; v.mode = mode; v.want = want;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({o_valid, got_res()} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", {o_valid, got_res()});
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b required 1", o_ready);
    end
  endtask

  task automatic test_directed();
    vec_t vs[$];
    vs.push_back(mk(8'b1_0100_100, 1'b0, 4'd5,  3'd0, {4'b0100, 4'd5,  1'b0, 1'b1, 1'b0}));
    vs.push_back(mk(8'b1_0101_100, 1'b0, 4'd5,  3'd0, {4'b0110, 4'd5,  1'b0, 1'b1, 1'b0}));
    vs.push_back(mk(8'b1_0100_101, 1'b0, 4'd5,  3'd0, {4'b0101, 4'd5,  1'b0, 1'b1, 1'b0}));
    vs.push_back(mk(8'b1_1111_110, 1'b0, 4'd5,  3'd0, {4'b0000, 4'd6,  1'b0, 1'b1, 1'b0}));
    vs.push_back(mk(8'b1_1111_110, 1'b0, 4'd14, 3'd0, {4'b0000, 4'd15, 1'b0, 1'b1, 1'b1}));
    vs.push_back(mk(8'b1_1111_110, 1'b0, 4'd14, 3'd1, {4'b1111, 4'd14, 1'b0, 1'b1, 1'b0}));
    vs.push_back(mk(8'b1_0010_001, 1'b0, 4'd5,  3'd2, {4'b0011, 4'd5,  1'b0, 1'b1, 1'b0}));
    vs.push_back(mk(8'b1_0010_001, 1'b1, 4'd5,  3'd2, {4'b0010, 4'd5,  1'b1, 1'b1, 1'b0}));
    vs.push_back(mk(8'b1_0010_001, 1'b1, 4'd5,  3'd3, {4'b0011, 4'd5,  1'b1, 1'b1, 1'b0}));
    vs.push_back(mk(8'b1_0010_001, 1'b0, 4'd5,  3'd4, {4'b0010, 4'd5,  1'b0, 1'b1, 1'b0}));
    vs.push_back(mk(8'b1_0101_111, 1'b0, 4'd15, 3'd2, {4'b0101, 4'd15, 1'b0, 1'b0, 1'b0}));
    vs.push_back(mk(8'b1_0101_100, 1'b0, 4'd5,  3'd7, {4'b0110, 4'd5,  1'b0, 1'b1, 1'b0}));
    for (int md = 0; md < 8; md++) begin
      logic sg;
      sg = 1'($urandom);
      vs.push_back(mk(8'b1_0010_000, sg, 4'd5, 3'(md), {4'b0010, 4'd5, sg, 1'b0, 1'b0}));
    end
    foreach (vs[i]) begin
      @(negedge clk);
      i_ready = 1'b1;
      i_valid = 1'b1;
      i_bin = vs[i].bin; i_sign = vs[i].sign; i_exp = vs[i].exp; i_mode = vs[i].mode;
      #1;
      n_vec++;
      if (o_ready !== 1'b1) begin
        n_err++;
        $display("FAIL dir_ready[%0d]: got %b required 1", i, o_ready);
      end
      @(negedge clk);
      i_valid = 1'b0;
      n_vec++;
      if (o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir_latency1[%0d]: o_valid got %b required 0", i, o_valid);
      end
      @(negedge clk);
      n_vec++;
      if (o_valid !== 1'b1 || got_res() !== vs[i].want) begin
        n_err++;
        $display("FAIL dir_result[%0d]: got v=%b %h required v=1 %h", i, o_valid, got_res(),
                 vs[i].want);
      end
    end
  endtask

  // bp = 1: five back-to-back beats, downstream stalled in cycles 2..5.
  // bp = 0: random valid/ready traffic for ncyc cycles.
  task automatic test_stream(input bit bp, input int ncyc);
    res_t q[$];
    int   cnt = 0;
    int   sent = 0;
    bit   saw_block = 1'b0;
    bit   was_held = 1'b0;
    bit   exp_rdy;
    for (int c = 0; c < ncyc + 40; c++) begin
      @(negedge clk);
      if (c >= ncyc && q.size() == 0) break;
      if (was_held) begin
        n_vec++;
        if (o_valid !== 1'b1) begin
          n_err++;
          $display("FAIL hold_valid[c%0d]: got %b required 1", c, o_valid);
        end
      end
      if (c >= ncyc) begin
        i_ready = 1'b1; i_valid = 1'b0;
      end else if (bp) begin
        i_ready = !(c >= 2 && c <= 5);
        i_valid = (sent < 5);
      end else begin
        i_ready = ($urandom_range(0, 3) != 0);
        i_valid = 1'($urandom);
      end
      i_bin  = {1'b1, 7'($urandom)};
      i_sign = 1'($urandom);
      i_exp  = 4'($urandom_range(0, 15));
      i_mode = 3'($urandom_range(0, 7));
      #1;
      exp_rdy = (cnt < 2) || i_ready;
      if (!exp_rdy) saw_block = 1'b1;
      n_vec++;
      if (o_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL stream_ready[c%0d]: got %b required %b (inflight %0d)", c, o_ready,
                 exp_rdy, cnt);
      end
      was_held = 1'b0;
      if (o_valid === 1'b1) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL stream_spurious[c%0d]: o_valid got 1 required 0", c);
        end else if (got_res() !== q[0]) begin
          n_err++;
          $display("FAIL stream_data[c%0d]: got %h required %h", c, got_res(), q[0]);
        end
        if (q.size() != 0) begin
          if (i_ready) begin
            void'(q.pop_front());
            cnt--;
          end else begin
            was_held = 1'b1;
          end
        end
      end
      if (i_valid && exp_rdy) begin
        q.push_back(model(i_bin, i_sign, i_exp, i_mode));
        cnt++;
        sent++;
      end
    end
    i_valid = 1'b0;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL stream_drain: got %0d beats outstanding required 0", q.size());
    end
    if (bp) begin
      n_vec++;
      if (!saw_block || sent != 5) begin
        n_err++;
        $display("FAIL bp_blocked: got block=%b sent=%0d required block=1 sent=5", saw_block,
                 sent);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t want;
    @(negedge clk);
    i_ready = 1'b0; i_valid = 1'b1;
    i_bin = 8'b1_0110_101; i_sign = 1'b0; i_exp = 4'd3; i_mode = 3'd0;
    @(negedge clk);
    i_bin = 8'b1_1001_011;
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({o_valid, got_res()} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: got %h required 0", {o_valid, got_res()});
    end
    @(negedge clk);
    rst = 1'b0;
    i_ready = 1'b1;
    #1;
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_ready: got %b required 1", o_ready);
    end
    i_valid = 1'b1;
    i_bin = 8'b1_0111_110; i_sign = 1'b1; i_exp = 4'd9; i_mode = 3'd3;
    want = model(i_bin, i_sign, i_exp, i_mode);
    @(negedge clk);
    i_valid = 1'b0;
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_latency1: o_valid got %b required 0", o_valid);
    end
    @(negedge clk);
    n_vec++;
    if (o_valid !== 1'b1 || got_res() !== want) begin
      n_err++;
      $display("FAIL midrst_result: got v=%b %h required v=1 %h", o_valid, got_res(), want);
    end
    @(negedge clk);
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_stale: o_valid got %b required 0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream(1'b1, 12);
    test_stream(1'b0, 400);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ipsxe_floating_point_rounder_pipe_v1_0.md
Name: ipsxe_floating_point_rounder_pipe_v1_0

Overview:
- Pipelined, multi-mode rounding stage for the floating-point datapath (sqrt, div, mul back-ends).
- Takes a normalised binary significand with extra low-order bits, sign and biased exponent, and rounds the significand to MAN_W bits under a selectable IEEE-754 mode.
- Propagates the carry into the exponent and flags inexact/overflow.
- Elastic valid/ready handshake so it drops between existing pipeline stages without stalls.

Parameters:
- MAN_W, 23, stored mantissa width (hidden bit excluded).
- EXP_W, 8, biased exponent width.
- BIN_W, 28, input significand width: bit BIN_W-1 is the hidden 1, then MAN_W mantissa bits, then GRD = BIN_W-1-MAN_W round bits. Elaboration error if GRD < 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept an input this cycle.
- i_bin  in  BIN_W  normalised significand.
- i_sign  in  1  sign of operand.
- i_exp  in  EXP_W  biased exponent before rounding.
- i_mode  in  3  0=RNE, 1=RTZ, 2=RUP (toward +inf), 3=RDN (toward -inf), 4=RMM (ties away); 5..7 behave as RNE.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts output.
- o_man  out  MAN_W  rounded mantissa.
- o_exp  out  EXP_W  adjusted exponent.
- o_sign  out  1  sign, passed through.
- o_inexact  out  1  any discarded bit was 1.
- o_overflow  out  1  rounding carried the exponent to all-ones.

Interface: one clock, i_clk; reset i_rst is asynchronous and active-high.

Behaviour:
- Field split:
  - m = i_bin[BIN_W-2:GRD]
  - lsb = m[0]
  - g = i_bin[GRD-1]
  - s = OR of i_bin[GRD-2:0]
- Increment decision inc:
  - RNE: g & (s | lsb)
  - RTZ: 0
  - RUP: (g|s) & ~sign
  - RDN: (g|s) & sign
  - RMM: g
- o_inexact = g | s, regardless of mode.
- Stage 1 registers m, inc, inexact, sign, exp.
- Stage 2 computes {c, sum} = m + inc at MAN_W+1 bits:
  - c=0: o_man = sum, o_exp = exp.
  - c=1: o_man = 0, o_exp = exp+1.
  - If the adjusted exponent equals all-ones: o_overflow = 1 and o_man is forced to 0 (infinity).
- Special input: i_exp all-ones (inf/NaN) passes m and exp unchanged with inc=0, inexact=0, overflow=0.
- Latency: exactly 2 cycles from an accepted input to o_valid when never stalled; throughput 1 beat/cycle.
- Handshake:
  - Input accepted when i_valid & o_ready. Output consumed when o_valid & i_ready.
  - Each stage loads when it is empty or its downstream stage advances.
  - o_ready = ~s1_valid | ~s2_valid | i_ready. It is combinational and does not depend on i_valid.
  - Data outputs hold stable while o_valid & ~i_ready.
  - Capacity is 2 beats. No loss, no duplication, order preserved.
- Simultaneous accept and consume with both stages full: both stages shift in the same cycle.
- Reset: all valid flags and all outputs go to 0 immediately and asynchronously. In-flight beats are discarded. o_ready is 1 in the first cycle after reset deassertion.
- No X propagation: data registers load only when their stage loads.

Decomposition:
- Shared package ipsxe_floating_point_pkg holds:
  - mode constants RM_RNE=0, RM_RTZ=1, RM_RUP=2, RM_RDN=3, RM_RMM=4
  - localparam function for GRD
- Sub-module: ipsxe_floating_point_round_dec_v1_0, combinational inc/inexact decision (mode, sign, lsb, g, s), reused by other datapaths.
- Stage registers and handshake stay in the top.

Test Plan (bench overrides MAN_W=4, EXP_W=4, BIN_W=8, so GRD=3):
- RNE ties:
  - i_bin=8'b1_0100_100, exp=5 -> o_man=4'b0100, o_exp=5, inexact=1.
  - i_bin=8'b1_0101_100 -> o_man=4'b0110.
  - i_bin=8'b1_0100_101 -> o_man=4'b0101.
- Carry: i_bin=8'b1_1111_110, exp=5, RNE -> o_man=0, o_exp=6, overflow=0, inexact=1.
- Overflow: same i_bin, exp=14, RNE -> o_exp=15, o_man=0, overflow=1. Same with RTZ -> o_man=4'b1111, o_exp=14, overflow=0, inexact=1.
- Directed modes with i_bin=8'b1_0010_001:
  - RUP, sign=0 -> o_man=0011.
  - RUP, sign=1 -> 0010.
  - RDN, sign=1 -> 0011.
  - RMM -> 0010.
  - Exact input 8'b1_0010_000 -> inexact=0 in all modes.
- Backpressure:
  - Feed 5 back-to-back beats with i_ready=0 for cycles 2-5 -> o_ready=0 once both stages are full.
  - After i_ready returns to 1, all 5 beats emerge in order with held-stable data; latency is 2 when unstalled.
- Reset mid-operation: assert i_rst with 2 beats in flight -> o_valid=0 and all outputs 0 at once; after release, o_ready=1 and a new beat emerges 2 cycles after acceptance.
